// File: rtl/phys_free_list.sv
// Physical register free list: circular tag buffer with speculative head,
// commit head and tail. FREELIST_ERROR_CHK_EN adds a sticky misuse flag.
module phys_free_list #(
    parameter int PHYS_ADDRWIDTH = 6,
    parameter int NUM_ARCH       = 32
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      FREEZE,
    input  logic                      tFL_allocReq_IN,
    output logic [PHYS_ADDRWIDTH-1:0] fFL_headReg_OUT,
    output logic                      fFL_empty_OUT,
    output logic [PHYS_ADDRWIDTH:0]   fFL_count_OUT,
    input  logic                      tFL_releaseReq_IN,
    input  logic [PHYS_ADDRWIDTH-1:0] tFL_releaseReg_IN,
    input  logic                      tFL_retireAlloc_IN,
    input  logic                      tFL_flush_IN,
    output logic                      fFL_error_OUT
);
    localparam int PW       = PHYS_ADDRWIDTH + 1;
    localparam int NUM_PHYS = 1 << PHYS_ADDRWIDTH;
    localparam int NUM_FREE = NUM_PHYS - NUM_ARCH;
    localparam logic [PW-1:0] FULL_OCC   = PW'(NUM_PHYS);
    localparam logic [PW-1:0] RESET_TAIL = PW'(NUM_FREE);

    logic [PHYS_ADDRWIDTH-1:0] fl_buf [NUM_PHYS];
    logic [PW-1:0] spec_head, commit_head, tail;
    logic [PW-1:0] spec_next, commit_next, tail_next;
    logic [PW-1:0] count, occupancy;
    logic          empty, full, head_eq;
    logic          do_alloc, do_release, do_retire;

    always_comb begin
        count      = tail - spec_head;
        occupancy  = tail - commit_head;
        empty      = (count == '0);
        full       = (occupancy == FULL_OCC);
        head_eq    = (commit_head == spec_head);
        // a flush discards the speculative head, so a same-cycle alloc is dropped
        do_alloc   = tFL_allocReq_IN && !empty && !tFL_flush_IN;
        do_release = tFL_releaseReq_IN && !full;
        do_retire  = tFL_retireAlloc_IN && !head_eq;
        commit_next = commit_head + PW'(do_retire);
        spec_next   = tFL_flush_IN ? commit_next : spec_head + PW'(do_alloc);
        tail_next   = tail + PW'(do_release);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            spec_head   <= '0;
            commit_head <= '0;
            tail        <= RESET_TAIL;
            for (int i = 0; i < NUM_PHYS; i++)
                fl_buf[i] <= (i < NUM_FREE) ? PHYS_ADDRWIDTH'(NUM_ARCH + i) : '0;
        end else if (!FREEZE) begin
            spec_head   <= spec_next;
            commit_head <= commit_next;
            tail        <= tail_next;
            if (do_release)
                fl_buf[tail[PHYS_ADDRWIDTH-1:0]] <= tFL_releaseReg_IN;
        end
    end

    assign fFL_count_OUT   = count;
    assign fFL_empty_OUT   = empty;
    assign fFL_headReg_OUT = fl_buf[spec_head[PHYS_ADDRWIDTH-1:0]];

`ifdef FREELIST_ERROR_CHK_EN
    logic error_q;
    logic misuse;

    assign misuse = (tFL_allocReq_IN && empty) ||
                    (tFL_releaseReq_IN && full) ||
                    (tFL_retireAlloc_IN && head_eq);

    always_ff @(posedge CLK) begin
        if (!RESET)
            error_q <= 1'b0;
        else if (!FREEZE && misuse)
            error_q <= 1'b1;
    end

    assign fFL_error_OUT = error_q;
`else
    assign fFL_error_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Scoreboard bench for phys_free_list: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_phys_free_list;
    localparam int PAW = 6;
    localparam int NA  = 32;
`ifdef FREELIST_ERROR_CHK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic           CLK = 1'b0;
    logic           RESET = 1'b0;
    logic           FREEZE = 1'b0;
    logic           alloc = 1'b0;
    logic           rel = 1'b0;
    logic [PAW-1:0] rel_reg = '0;
    logic           retire = 1'b0;
    logic           flush = 1'b0;
    logic [PAW-1:0] head;
    logic           empty;
    logic [PAW:0]   count;
    logic           err;

    phys_free_list #(.PHYS_ADDRWIDTH(PAW), .NUM_ARCH(NA)) dut (
        .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE),
        .tFL_allocReq_IN(alloc), .fFL_headReg_OUT(head),
        .fFL_empty_OUT(empty), .fFL_count_OUT(count),
        .tFL_releaseReq_IN(rel), .tFL_releaseReg_IN(rel_reg),
        .tFL_retireAlloc_IN(retire), .tFL_flush_IN(flush),
        .fFL_error_OUT(err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        string nm;
        int    due;
        int    cnt;
        bit    emp;
        int    hd;
        bit    er;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int checks = 0;
    int failures = 0;

    task automatic chk(string nm, string field, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s.%s actual=%0d expected=%0d (cycle %0d)", nm, field, act, req, cyc);
        end
    endtask

    always @(negedge CLK) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            mon_e = q.pop_front();
            chk(mon_e.nm, "count", int'(count), mon_e.cnt);
            chk(mon_e.nm, "empty", int'(empty), int'(mon_e.emp));
            if (!mon_e.emp) chk(mon_e.nm, "head", int'(head), mon_e.hd);
            chk(mon_e.nm, "error", int'(err), int'(mon_e.er));
        end
    end

    // Expected outputs for the state currently held (after the last edge).
    task automatic expect_out(string nm, int cnt, int hd, bit er);
        exp_t e;
        e.nm = nm; e.due = cyc; e.cnt = cnt; e.emp = (cnt == 0); e.hd = hd; e.er = er;
        q.push_back(e);
    endtask

    // Inputs set here are consumed by the following rising edge.
    task automatic drive(bit a, bit r, logic [PAW-1:0] rr, bit ret, bit fl, bit fz);
        @(posedge CLK); #1;
        alloc = a; rel = r; rel_reg = rr; retire = ret; flush = fl; FREEZE = fz;
    endtask

    task automatic idle();
        drive(0, 0, '0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        alloc = 0; rel = 0; rel_reg = '0; retire = 0; flush = 0; FREEZE = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        do_reset();
        expect_out("reset", 32, 32, 0);

        // three allocs present 32,33,34 then 35
        drive(1, 0, '0, 0, 0, 0); expect_out("alloc0", 32, 32, 0);
        drive(1, 0, '0, 0, 0, 0); expect_out("alloc1", 31, 33, 0);
        drive(1, 0, '0, 0, 0, 0); expect_out("alloc2", 30, 34, 0);
        idle();                   expect_out("alloc3", 29, 35, 0);

        // 4 allocs then retire+flush (+ignored alloc) -> count 31, head 33
        do_reset();
        repeat (4) drive(1, 0, '0, 0, 0, 0);
        drive(1, 0, '0, 1, 1, 0); expect_out("pre_flush", 28, 36, 0);
        idle();                   expect_out("flush", 31, 33, 0);

        // drain to empty, alloc while empty, then release 5 refills
        do_reset();
        repeat (32) drive(1, 0, '0, 0, 0, 0);
        drive(1, 0, '0, 0, 0, 0); expect_out("drained", 0, 0, 0);
        drive(0, 1, 6'd5, 0, 0, 0); expect_out("alloc_empty", 0, 0, ERR_ON);
        idle();                     expect_out("refill5", 1, 5, ERR_ON);

        // count=10, alloc+release 7 together; 7 becomes 10th allocated tag
        do_reset();
        repeat (22) drive(1, 0, '0, 0, 0, 0);
        drive(1, 1, 6'd7, 0, 0, 0); expect_out("count10", 10, 54, 0);
        for (int j = 0; j < 10; j++) begin
            drive(1, 0, '0, 0, 0, 0);
            expect_out($sformatf("post_swap%0d", j), 10 - j, (j < 9) ? 55 + j : 7, 0);
        end
        idle(); expect_out("swap_drained", 0, 0, 0);

        // fill to full, release while full is ignored
        do_reset();
        for (int i = 0; i < 32; i++) drive(0, 1, PAW'(i), 0, 0, 0);
        drive(0, 1, 6'd9, 0, 0, 0); expect_out("full", 64, 32, 0);
        idle();                     expect_out("rel_full", 64, 32, ERR_ON);

        // retire with nothing allocated is ignored
        do_reset();
        drive(0, 0, '0, 1, 0, 0);
        idle(); expect_out("retire_none", 32, 32, ERR_ON);

        // reset wins over freeze and requests
        drive(1, 0, '0, 0, 0, 1);
        do_reset(); expect_out("reset_frozen", 32, 32, 0);

        // freeze holds everything even with flush requested
        drive(1, 0, '0, 0, 0, 0);
        drive(1, 0, '0, 0, 0, 0);
        drive(1, 1, 6'd9, 1, 1, 1); expect_out("pre_freeze", 30, 34, 0);
        idle();                     expect_out("freeze", 30, 34, 0);
        idle();                     expect_out("post_freeze", 30, 34, 0);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge CLK);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/phys_free_list.md
PHYS_FREE_LIST -- requirements
Module: phys_free_list

Interface
REQ-001 SHALL have parameter PHYS_ADDRWIDTH, default 6, physical register tag width; there are NUM_PHYS = 1<<PHYS_ADDRWIDTH physical registers.
REQ-002 SHALL have parameter NUM_ARCH, default 32, number of architectural registers; NUM_FREE = NUM_PHYS - NUM_ARCH.
REQ-003 SHALL have port CLK  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port FREEZE  in  1  pipeline stall; 1 blocks every state update.
REQ-006 SHALL have port tFL_allocReq_IN  in  1  rename pops the head tag.
REQ-007 SHALL have port fFL_headReg_OUT  out  PHYS_ADDRWIDTH  tag at the speculative head; valid when fFL_empty_OUT=0.
REQ-008 SHALL have port fFL_empty_OUT  out  1  no free tags.
REQ-009 SHALL have port fFL_count_OUT  out  PHYS_ADDRWIDTH+1  free tags available to rename.
REQ-010 SHALL have port tFL_releaseReq_IN  in  1  commit frees one tag.
REQ-011 SHALL have port tFL_releaseReg_IN  in  PHYS_ADDRWIDTH  tag being freed, which is the previous mapping of the retired destination.
REQ-012 SHALL have port tFL_retireAlloc_IN  in  1  commit retired an instruction that allocated a tag.
REQ-013 SHALL have port tFL_flush_IN  in  1  misprediction/exception flush from commit.
REQ-014 SHALL have port fFL_error_OUT  out  1  sticky misuse flag (see Configuration).

Function
REQ-015 SHALL store tags in a circular buffer of NUM_PHYS entries with PHYS_ADDRWIDTH+1-bit pointers: specHead, commitHead, and tail. Wrap-around SHALL be modulo NUM_PHYS, with the extra bit distinguishing full from empty.
REQ-016 SHALL drive fFL_count_OUT = tail - specHead, fFL_empty_OUT = (count==0), and fFL_headReg_OUT = buf[specHead] combinationally.
REQ-017 When allocReq=1 and empty=0, the block SHALL advance specHead by 1 at the clock edge; allocReq while empty SHALL be ignored.
REQ-018 When releaseReq=1 and the buffer is not full, the block SHALL write releaseReg at tail and advance tail; release while full (tail - commitHead == NUM_PHYS) SHALL be ignored.
REQ-019 When retireAlloc=1 and commitHead != specHead, the block SHALL advance commitHead by 1; otherwise the request SHALL be ignored.
REQ-020 When flush=1, the block SHALL set specHead to commitHead after this cycle's retireAlloc is applied. Any allocReq in the same cycle SHALL be ignored. Any releaseReq in the same cycle SHALL still be performed.
REQ-021 When alloc and release occur in the same cycle, both SHALL be performed and count SHALL be unchanged. There is no bypass: a release SHALL NOT satisfy an alloc made while empty in the same cycle.
REQ-022 New values of all outputs SHALL be visible the cycle after the causing edge, giving single-cycle latency.
REQ-023 FREEZE=1 SHALL hold every pointer, every buffer entry and fFL_error_OUT, including when flush is requested.

Reset
REQ-024 On RESET=0 at a clock edge, the block SHALL set buf[i] = NUM_ARCH+i for i in 0..NUM_FREE-1, specHead = commitHead = 0, tail = NUM_FREE, and fFL_error_OUT = 0.
REQ-025 After reset, the outputs SHALL be fFL_count_OUT = NUM_FREE, fFL_empty_OUT = 0 and fFL_headReg_OUT = NUM_ARCH.
REQ-026 Reset SHALL take priority over FREEZE and all requests, including when it is asserted mid-operation.

Configuration
REQ-027 Macro FREELIST_ERROR_CHK_EN defined: fFL_error_OUT SHALL set to 1 on any ignored request (alloc when empty, release when full, retireAlloc with commitHead==specHead) and stay set until reset.
REQ-028 Macro FREELIST_ERROR_CHK_EN undefined: fFL_error_OUT SHALL be constant 0 and the checking logic SHALL be absent.

Verification (PHYS_ADDRWIDTH=6, NUM_ARCH=32)
REQ-029 Reset, then 3 allocs -> headReg presents 32, 33, 34 on successive cycles; afterwards count=29 and headReg=35.
REQ-030 32 allocs from reset, then 1 more -> empty=1, count=0, pointers unchanged, error=1 (macro defined) / 0 (undefined).
REQ-031 Count=0, release reg 5 -> next cycle empty=0, count=1, headReg=5.
REQ-032 From reset: 4 allocs (32..35), then retireAlloc=1 and flush=1 in the same cycle -> count=31, headReg=33.
REQ-033 Count=10, alloc and release reg 7 in the same cycle -> count=10, and reg 7 is the 10th tag allocated afterwards.
REQ-034 FREEZE=1 with alloc, release and flush all asserted -> every output unchanged on the next cycle.
